tetris_2048_grid_core: RTL and testbench

Parametrised successor of the 4x4 drop-stack 2048 core. A player moves a cursor across COLS columns and drops LFSR-chosen tiles that stack under gravity. Equal tiles merge in cascaded vertical chains, one merge per cycle, with score accumulation. The block sits between the debounced button front-end and the VGA/board renderer, and exports a busy flag so the front-end knows when presses are ignored.

---
 rtl/tetris_2048_grid_core_if.sv | 39 +++
 rtl/tetris_2048_grid_core.sv | 196 +++++++++++++++++++
 tb/tb_tetris_2048_grid_core.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tetris_2048_grid_core_if.sv
// Button/board bundle between the debounced front-end, the 2048 grid core and the renderer.
// The hiscore signal exists only when TETRIS_2048_HISCORE_EN is defined.
interface tetris_2048_grid_core_if #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int TW      = 5,
  parameter int SCORE_W = 16
);
  localparam int CW = $clog2(COLS);

  logic                      btn_l;
  logic                      btn_r;
  logic                      btn_drop;
  logic [ROWS*COLS*TW-1:0]   board_flat;
  logic [SCORE_W-1:0]        score;
  logic                      game_over;
  logic [CW-1:0]             cursor_col;
  logic [TW-1:0]             spawn_val;
  logic                      busy;
`ifdef TETRIS_2048_HISCORE_EN
  logic [SCORE_W-1:0]        hiscore;
`endif

  modport master (
    output btn_l, btn_r, btn_drop,
    input  board_flat, score, game_over, cursor_col, spawn_val, busy
`ifdef TETRIS_2048_HISCORE_EN
    , input hiscore
`endif
  );

  modport slave (
    input  btn_l, btn_r, btn_drop,
    output board_flat, score, game_over, cursor_col, spawn_val, busy
`ifdef TETRIS_2048_HISCORE_EN
    , output hiscore
`endif
  );
endinterface

// File: rtl/tetris_2048_grid_core.sv
// Drop-stack 2048 core: cursor, LFSR tile spawn, gravity placement and cascaded vertical merges.
// Optional TETRIS_2048_HISCORE_EN adds a persistent hiscore and restart-from-OVER on btn_drop.
module tetris_2048_grid_core #(
  parameter int          ROWS      = 4,
  parameter int          COLS      = 4,
  parameter int          TW        = 5,
  parameter int          SCORE_W   = 16,
  parameter int          MAX_SPAWN = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst,
  tetris_2048_grid_core_if.slave    bus
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [TW-1:0] TILE_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_FIND, S_PLACE, S_MERGE, S_SPAWN, S_OVER} state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      cell_q [ROWS][COLS];
  logic [SCORE_W-1:0] score_q;
  logic [CW-1:0]      cur_q;
  logic [TW-1:0]      spawn_q;
  logic [15:0]        lfsr_q;
  logic [RW-1:0]      pos_q;
`ifdef TETRIS_2048_HISCORE_EN
  logic [SCORE_W-1:0] hiscore_q;
`endif

  logic [TW-1:0]      col_cell [ROWS];
  logic               has_empty;
  logic [RW-1:0]      empty_row;
  logic               top_merge;
  logic [RW-1:0]      pos_nx;
  logic [TW-1:0]      e_cur;
  logic               can_merge;
  logic               busy_c;
  logic               over_c;

  // Galois form, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [TW-1:0] spawn_pick(input logic [15:0] v);
    int m;
    m = int'({16'd0, v}) % MAX_SPAWN;
    return TW'(m + 1);
  endfunction

  // score + 2^ex, clamped to all ones on overflow.
  function automatic logic [SCORE_W-1:0] score_add(input logic [SCORE_W-1:0] s,
                                                   input logic [TW:0]        ex);
    logic [SCORE_W:0] sum;
    if (int'(ex) >= SCORE_W) return '1;
    sum = {1'b0, s} + ((SCORE_W+1)'(1) << ex);
    if (sum[SCORE_W]) return '1;
    return sum[SCORE_W-1:0];
  endfunction

  // Column under the cursor; stacks are contiguous from the bottom, so the
  // last empty row scanning downward is the landing row.
  always_comb begin
    has_empty = 1'b0;
    empty_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      col_cell[r] = cell_q[r][cur_q];
      if (cell_q[r][cur_q] == '0) begin
        has_empty = 1'b1;
        empty_row = RW'(r);
      end
    end
    top_merge = !has_empty && (col_cell[0] == spawn_q) && (spawn_q != TILE_MAX);
    pos_nx    = pos_q + RW'(1);
    e_cur     = col_cell[pos_q];
    can_merge = (int'(pos_q) < ROWS-1) && (col_cell[pos_nx] == e_cur) && (e_cur != TILE_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.btn_drop) state_d = S_FIND;
      S_FIND: begin
        if (has_empty)      state_d = S_PLACE;
        else if (top_merge) state_d = S_MERGE;
        else                state_d = S_OVER;
      end
      S_PLACE: state_d = S_MERGE;
      S_MERGE: state_d = can_merge ? S_MERGE : S_SPAWN;
      S_SPAWN: state_d = S_IDLE;
      S_OVER: begin
`ifdef TETRIS_2048_HISCORE_EN
        if (bus.btn_drop) state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    over_c = 1'b0;
    case (state_q)
      S_FIND, S_PLACE, S_MERGE, S_SPAWN: busy_c = 1'b1;
      S_OVER:                            over_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          cell_q[r][c] <= '0;
      score_q <= '0;
      cur_q   <= '0;
      pos_q   <= '0;
      spawn_q <= TW'(1);
      lfsr_q  <= LFSR_SEED;
`ifdef TETRIS_2048_HISCORE_EN
      hiscore_q <= '0;
`endif
    end else begin
      lfsr_q <= lfsr_step(lfsr_q);
      case (state_q)
        S_IDLE: begin
          if (!bus.btn_drop) begin
            if (bus.btn_l && !bus.btn_r && cur_q != '0)
              cur_q <= cur_q - CW'(1);
            else if (bus.btn_r && !bus.btn_l && int'(cur_q) != COLS-1)
              cur_q <= cur_q + CW'(1);
          end
        end
        S_FIND: begin
          if (has_empty) begin
            pos_q <= empty_row;
          end else if (top_merge) begin
            cell_q[0][cur_q] <= spawn_q + TW'(1);
            score_q          <= score_add(score_q, {1'b0, spawn_q} + (TW+1)'(1));
            pos_q            <= '0;
          end
`ifdef TETRIS_2048_HISCORE_EN
          else if (score_q > hiscore_q) begin
            hiscore_q <= score_q;
          end
`endif
        end
        S_PLACE: cell_q[pos_q][cur_q] <= spawn_q;
        S_MERGE: begin
          // The merged tile moves into the occupied cell below, so no gap forms.
          if (can_merge) begin
            cell_q[pos_nx][cur_q] <= e_cur + TW'(1);
            cell_q[pos_q][cur_q]  <= '0;
            score_q               <= score_add(score_q, {1'b0, e_cur} + (TW+1)'(1));
            pos_q                 <= pos_nx;
          end
        end
        S_SPAWN: spawn_q <= spawn_pick(lfsr_q);
        S_OVER: begin
`ifdef TETRIS_2048_HISCORE_EN
          if (bus.btn_drop) begin
            for (int r = 0; r < ROWS; r++)
              for (int c = 0; c < COLS; c++)
                cell_q[r][c] <= '0;
            score_q <= '0;
            cur_q   <= '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign bus.board_flat[((r*COLS+c)*TW) +: TW] = cell_q[r][c];
    end
  end

  assign bus.score      = score_q;
  assign bus.game_over  = over_c;
  assign bus.cursor_col = cur_q;
  assign bus.spawn_val  = spawn_q;
  assign bus.busy       = busy_c;
`ifdef TETRIS_2048_HISCORE_EN
  assign bus.hiscore    = hiscore_q;
`endif
endmodule

// File: tb/tb_tetris_2048_grid_core.sv
// Bench for tetris_2048_grid_core: cursor vector table, directed drop/merge/over sequences,
// and random play checked against an instant-resolution game model.
module tb_tetris_2048_grid_core;
  localparam int          ROWS      = 4;
  localparam int          COLS      = 4;
  localparam int          TW        = 5;
  localparam int          SCORE_W   = 16;
  localparam int          MAX_SPAWN = 2;
  localparam logic [15:0] SEED      = 16'hACE1;
  localparam int          NB        = ROWS*COLS*TW;
  localparam int          TMAX      = (1 << TW) - 1;
  localparam longint      SMAX      = (64'd1 << SCORE_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tetris_2048_grid_core_if #(.ROWS(ROWS), .COLS(COLS), .TW(TW), .SCORE_W(SCORE_W)) bus ();

  tetris_2048_grid_core #(
    .ROWS(ROWS), .COLS(COLS), .TW(TW), .SCORE_W(SCORE_W),
    .MAX_SPAWN(MAX_SPAWN), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Game model: the whole drop resolves instantly; only the spawn draw needs the LFSR history.
  int     m_cell [ROWS][COLS];
  longint m_score;
  longint m_hi;
  int     m_cur;
  int     m_spawn;
  bit     m_over;
  logic [15:0] m_lfsr, m_lfsr_prev;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
    logic [15:0] x = v;
    for (int i = 0; i < n; i++) x = lfsr_next(x);
    return x;
  endfunction

  always @(posedge clk) begin
    m_lfsr_prev <= m_lfsr;
    m_lfsr      <= rst ? SEED : lfsr_next(m_lfsr);
  end

  typedef struct {
    bit l;
    bit r;
    int exp;
  } cur_vec_t;
  cur_vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_board(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: board got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] model_flat();
    logic [NB-1:0] f = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        f[(r*COLS+c)*TW +: TW] = TW'(m_cell[r][c]);
    return f;
  endfunction

  function automatic logic [TW-1:0] dcell(input int r, input int c);
    return bus.board_flat[(r*COLS+c)*TW +: TW];
  endfunction

  task automatic check_all(input string tag);
    chk_board({tag, ".board"}, bus.board_flat, model_flat());
    chk({tag, ".score"},     bus.score,      m_score);
    chk({tag, ".cursor"},    bus.cursor_col, m_cur);
    chk({tag, ".spawn"},     bus.spawn_val,  m_spawn);
    chk({tag, ".game_over"}, bus.game_over,  m_over);
    chk({tag, ".busy"},      bus.busy,       0);
`ifdef TETRIS_2048_HISCORE_EN
    chk({tag, ".hiscore"},   bus.hiscore,    m_hi);
`endif
  endtask

  task automatic model_clear_game();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        m_cell[r][c] = 0;
    m_score = 0;
    m_cur   = 0;
    m_over  = 0;
  endtask

  task automatic do_reset(input int n);
    bus.btn_l = 0; bus.btn_r = 0; bus.btn_drop = 0;
    rst = 1;
    repeat (n) @(posedge clk);
    #1;
    rst = 0;
    model_clear_game();
    m_spawn = 1;
    m_hi    = 0;
  endtask

  task automatic add_score(input int e);
    longint s = m_score + (64'd1 << e);
    m_score = (s > SMAX) ? SMAX : s;
  endtask

  // Resolve a drop of m_spawn into the cursor column; len is the expected busy cycle count.
  task automatic model_drop(output int len, output bit went_over);
    int c = m_cur;
    int tgt = -1;
    int pos, base, k;
    went_over = 0;
    for (int r = 0; r < ROWS; r++) if (m_cell[r][c] == 0) tgt = r;
    if (tgt >= 0) begin
      m_cell[tgt][c] = m_spawn; pos = tgt; base = 4;
    end else if (m_cell[0][c] == m_spawn && m_spawn != TMAX) begin
      m_cell[0][c] = m_spawn + 1; add_score(m_spawn + 1); pos = 0; base = 3;
    end else begin
      m_over = 1;
      if (m_score > m_hi) m_hi = m_score;
      went_over = 1;
      len = 1;
      return;
    end
    k = 0;
    while (pos < ROWS-1 && m_cell[pos+1][c] == m_cell[pos][c] && m_cell[pos][c] != TMAX) begin
      m_cell[pos+1][c] = m_cell[pos][c] + 1;
      m_cell[pos][c]   = 0;
      add_score(m_cell[pos+1][c]);
      pos++;
      k++;
    end
    len = base + k;
  endtask

  task automatic press(input bit l, input bit r);
    bus.btn_l = l; bus.btn_r = r;
    @(posedge clk); #1;
    bus.btn_l = 0; bus.btn_r = 0;
    if (!m_over) begin
      if (l && !r && m_cur > 0) m_cur--;
      else if (r && !l && m_cur < COLS-1) m_cur++;
    end
    chk("cursor", bus.cursor_col, m_cur);
  endtask

  task automatic move_to(input int col);
    while (m_cur != col) press(col < m_cur, col > m_cur);
  endtask

  // Drop into col; want != 0 picks an idle delay so the following spawn equals want.
  task automatic drop(input int col, input int want, output int busy_seen);
    int  len, d;
    bit  ov, found;
    move_to(col);
    model_drop(len, ov);
    d = $urandom_range(0, 3);
    if (want != 0 && !ov) begin
      found = 0;
      for (int i = 0; i < 64 && !found; i++) begin
        if (int'(lfsr_adv(m_lfsr, i + len) % MAX_SPAWN) + 1 == want) begin
          d = i; found = 1;
        end
      end
      chk("spawn_search", found, 1);
    end
    repeat (d) begin @(posedge clk); #1; end
    bus.btn_drop = 1;
    @(posedge clk); #1;
    bus.btn_drop = 0;
    busy_seen = 0;
    while (bus.busy === 1'b1 && busy_seen < 64) begin
      busy_seen++;
      {bus.btn_l, bus.btn_r, bus.btn_drop} = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
    end
    bus.btn_l = 0; bus.btn_r = 0; bus.btn_drop = 0;
    chk("busy_len", busy_seen, len);
    if (!ov) m_spawn = 1 + int'(m_lfsr_prev % MAX_SPAWN);
    if (want != 0 && !ov) chk("spawn_want", bus.spawn_val, want);
    check_all("drop");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bs;
    bus.btn_l = 0; bus.btn_r = 0; bus.btn_drop = 0;

    tbl[0]  = '{0, 1, 1};  tbl[1]  = '{0, 1, 2};  tbl[2]  = '{0, 1, 3};
    tbl[3]  = '{0, 1, 3};  tbl[4]  = '{0, 1, 3};  tbl[5]  = '{1, 1, 3};
    tbl[6]  = '{1, 0, 2};  tbl[7]  = '{1, 0, 1};  tbl[8]  = '{1, 0, 0};
    tbl[9]  = '{1, 0, 0};  tbl[10] = '{1, 1, 0};

    // Reset state
    do_reset(3);
    chk_board("rst.board", bus.board_flat, '0);
    chk("rst.score",     bus.score,      0);
    chk("rst.cursor",    bus.cursor_col, 0);
    chk("rst.busy",      bus.busy,       0);
    chk("rst.game_over", bus.game_over,  0);
    chk("rst.spawn",     bus.spawn_val,  1);

    // Cursor movement table
    for (int i = 0; i < 11; i++) begin
      bus.btn_l = tbl[i].l; bus.btn_r = tbl[i].r;
      @(posedge clk); #1;
      bus.btn_l = 0; bus.btn_r = 0;
      chk($sformatf("cursor_tbl[%0d]", i), bus.cursor_col, tbl[i].exp);
      m_cur = tbl[i].exp;
    end
    check_all("after_tbl");

    // Plain placement of a 2 into empty column 2
    do_reset(2);
    drop(0, 2, bs);
    drop(2, 0, bs);
    chk("place.busy", bs, 4);
    chk("place.cell32", dcell(3, 2), 2);
    chk("place.score", bus.score, 0);

    // Two-step cascade: bottom 2, then 1, then drop 1
    do_reset(2);
    drop(3, 2, bs);
    drop(0, 1, bs);
    drop(0, 1, bs);
    drop(0, 1, bs);
    chk("cascade.busy", bs, 6);
    chk("cascade.cell30", dcell(3, 0), 3);
    chk("cascade.cell20", dcell(2, 0), 0);
    chk("cascade.cell10", dcell(1, 0), 0);
    chk("cascade.score", bus.score, 12);

    // Full alternating column with top 2, drop 1 -> game over
    drop(1, 2, bs);
    drop(1, 1, bs);
    drop(1, 2, bs);
    drop(1, 1, bs);
    drop(1, 0, bs);
    chk("over.busy", bs, 1);
    chk("over.flag", bus.game_over, 1);
    chk("over.score", bus.score, 12);
`ifdef TETRIS_2048_HISCORE_EN
    chk("hi.value", bus.hiscore, 12);
    bus.btn_drop = 1;
    @(posedge clk); #1;
    bus.btn_drop = 0;
    model_clear_game();
    chk_board("hi.board", bus.board_flat, '0);
    chk("hi.score", bus.score, 0);
    chk("hi.game_over", bus.game_over, 0);
    chk("hi.keep", bus.hiscore, 12);
    check_all("hi.restart");
`else
    press(0, 1);
    press(1, 0);
    bus.btn_drop = 1;
    @(posedge clk); #1;
    bus.btn_drop = 0;
    repeat (3) begin @(posedge clk); #1; end
    chk("over.sticky", bus.game_over, 1);
    check_all("over.frozen");
`endif

    // Full column whose top matches the spawn merges instead of ending the game
    do_reset(2);
    drop(0, 2, bs);
    drop(3, 1, bs);
    drop(3, 2, bs);
    drop(3, 1, bs);
    drop(3, 1, bs);
    drop(3, 0, bs);
    chk("topmerge.busy", bs, 4);
    chk("topmerge.cell03", dcell(0, 3), 0);
    chk("topmerge.cell13", dcell(1, 3), 3);
    chk("topmerge.game_over", bus.game_over, 0);
    chk("topmerge.score", bus.score, 12);

    // Reset asserted while a merge is in progress
    do_reset(2);
    drop(0, 1, bs);
    bus.btn_drop = 1;
    @(posedge clk); #1;
    bus.btn_drop = 0;
    repeat (2) begin @(posedge clk); #1; end
    chk("midrst.busy_before", bus.busy, 1);
    rst = 1;
    @(posedge clk); #1;
    chk_board("midrst.board", bus.board_flat, '0);
    chk("midrst.score",     bus.score,      0);
    chk("midrst.cursor",    bus.cursor_col, 0);
    chk("midrst.busy",      bus.busy,       0);
    chk("midrst.game_over", bus.game_over,  0);
    chk("midrst.spawn",     bus.spawn_val,  1);
    rst = 0;
    model_clear_game();
    m_spawn = 1;
    m_hi    = 0;

    // Random play against the model
    for (int ep = 0; ep < 6; ep++) begin
      do_reset(2);
      for (int a = 0; a < 80 && !m_over; a++) begin
        case ($urandom_range(0, 5))
          0: press(1, 0);
          1: press(0, 1);
          2: press(1, 1);
          default: drop($urandom_range(0, COLS-1), 0, bs);
        endcase
      end
      if (m_over) begin
        press(0, 1);
        check_all("rand.over");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
